// File: rtl/ws2812_tx_if.sv
// Bus bundle between the LED frame transmitter and its host/RAM side.
// The master side drives the frame request and the RAM read data. The slave
// side is the transmitter, which drives status, the RAM read port and the line.
interface ws2812_tx_if #(
  parameter int BITS   = 24,
  parameter int AWIDTH = 3
);
  logic              start;
  logic              busy;
  logic              done;
  logic              re;
  logic [AWIDTH-1:0] raddr;
  logic [BITS-1:0]   rdata;
  logic              dout;

  modport master (
    output start,
    output rdata,
    input  busy,
    input  done,
    input  re,
    input  raddr,
    input  dout
  );

  modport slave (
    input  start,
    input  rdata,
    output busy,
    output done,
    output re,
    output raddr,
    output dout
  );
endinterface

// File: rtl/ws2812_tx.sv
// WS2812 one-wire frame transmitter. On start it walks RAM words
// 0..NLEDS-1 and sends each one MSB first with pulse-width coding. It then
// holds the line low for the latch period and pulses done.
// Every output is a flop. Next values are computed one cycle ahead so that
// the line changes exactly on the bit-cell boundaries.
module ws2812_tx #(
  parameter int NLEDS   = 8,
  parameter int BITS    = 24,
  parameter int AWIDTH  = $clog2(NLEDS),
  parameter int T_BIT   = 15,
  parameter int T0H     = 4,
  parameter int T1H     = 8,
  parameter int T_RESET = 600
) (
  input  logic         clk,
  input  logic         rst_n,
  ws2812_tx_if.slave   bus
);

  localparam int CMAX = (T_BIT > T_RESET) ? T_BIT : T_RESET;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int BW   = $clog2(BITS + 1);

  localparam logic [CW-1:0]     BIT_LAST   = CW'(T_BIT - 1);
  localparam logic [CW-1:0]     LATCH_LAST = CW'(T_RESET - 1);
  localparam logic [CW-1:0]     T0H_C      = CW'(T0H);
  localparam logic [CW-1:0]     T1H_C      = CW'(T1H);
  localparam logic [BW-1:0]     BITS_LAST  = BW'(BITS - 1);
  localparam logic [AWIDTH-1:0] LED_LAST   = AWIDTH'(NLEDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    SEND,
    LATCH
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cyc_q, cyc_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [AWIDTH-1:0] led_q, led_d;
  logic [BITS-1:0]   shreg_q, shreg_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              re_q, re_d;
  logic [AWIDTH-1:0] raddr_q, raddr_d;
  logic              dout_q, dout_d;

  logic [CW-1:0]     cyc_inc;
  logic [CW-1:0]     hi_len;

  assign cyc_inc = cyc_q + 1'b1;
  // High time of the bit currently in the MSB of the shift register.
  assign hi_len  = shreg_q[BITS-1] ? T1H_C : T0H_C;

  // Next-state and next-output computation for the frame sequencer.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    led_d   = led_q;
    shreg_d = shreg_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    re_d    = 1'b0;
    raddr_d = raddr_q;
    dout_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = FETCH;
          busy_d  = 1'b1;
          led_d   = '0;
          re_d    = 1'b1;
          raddr_d = '0;
        end
      end

      // The read was issued on entry. The RAM answers during LOAD.
      FETCH: begin
        state_d = LOAD;
      end

      // Every bit cell opens high (T0H > 0), so the line rises on entry to SEND.
      LOAD: begin
        shreg_d = bus.rdata;
        bit_d   = '0;
        cyc_d   = '0;
        state_d = SEND;
        dout_d  = 1'b1;
      end

      SEND: begin
        if (cyc_q == BIT_LAST) begin
          cyc_d = '0;
          if (bit_q == BITS_LAST) begin
            if (led_q == LED_LAST) begin
              state_d = LATCH;
              done_d  = (T_RESET == 1);
            end else begin
              led_d   = led_q + 1'b1;
              raddr_d = led_q + 1'b1;
              re_d    = 1'b1;
              state_d = FETCH;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            shreg_d = {shreg_q[BITS-2:0], 1'b0};
            dout_d  = 1'b1;
          end
        end else begin
          cyc_d  = cyc_inc;
          dout_d = (cyc_inc < hi_len);
        end
      end

      // done is raised so that it shows during the last latch cycle.
      LATCH: begin
        if (cyc_q == LATCH_LAST) begin
          state_d = IDLE;
          cyc_d   = '0;
          busy_d  = 1'b0;
        end else begin
          cyc_d  = cyc_inc;
          done_d = (cyc_inc == LATCH_LAST);
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs. Reset is asynchronous and forces the line low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      led_q   <= '0;
      shreg_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      re_q    <= 1'b0;
      raddr_q <= '0;
      dout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      led_q   <= led_d;
      shreg_q <= shreg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      re_q    <= re_d;
      raddr_q <= raddr_d;
      dout_q  <= dout_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.re    = re_q;
  assign bus.raddr = raddr_q;
  assign bus.dout  = dout_q;

endmodule

// File: doc/ws2812_tx.md
# ws2812_tx

Frame transmitter that reads LED colour words from the read port of the LED dual-port RAM and serialises them onto a single WS2812-style one-wire output. It is the consumer end of the LED buffer. The host side writes pixel words into the RAM. This block walks addresses 0..NLEDS-1 on each `start` and emits the bits with NRZ pulse-width coding. It finishes each frame with a low latch (reset) period.

## Interface
- `NLEDS`, 8: number of LEDs (RAM words) sent per frame, ≥1
- `BITS`, 24: bits per LED word, sent MSB first
- `AWIDTH`, $clog2(NLEDS): RAM read address width (must be ≥1)
- `T_BIT`, 15: clock cycles per bit period
- `T0H`, 4: high cycles for a 0 bit (0 < T0H < T1H)
- `T1H`, 8: high cycles for a 1 bit (T1H < T_BIT)
- `T_RESET`, 600: low cycles of the end-of-frame latch

Defaults suit a 12 MHz clock.

- `clk`, in, 1: single clock, all logic on the rising edge
- `rst_n`, in, 1: asynchronous, active-low reset
- `start`, in, 1: frame request pulse, sampled in IDLE only
- `busy`, out, 1: high from the cycle after an accepted start through the end of the latch period
- `done`, out, 1: one-cycle pulse when the latch period completes
- `re`, out, 1: RAM read enable
- `raddr`, out, AWIDTH: RAM read address
- `rdata`, in, BITS: RAM read data, valid the cycle after `re`
- `dout`, out, 1: serial LED data line

## Operation
- All outputs are registered.
- Reset values: `busy`=0, `done`=0, `re`=0, `raddr`=0, `dout`=0. State is IDLE and all counters are 0.
- States: IDLE → FETCH → LOAD → SEND → (FETCH | LATCH) → IDLE.
- **IDLE**
  - `start`=1 → FETCH with `led`=0.
  - `start` is ignored in every other state; there is no queuing.
- **FETCH** (1 cycle)
  - `re`=1 and `raddr`=`led`, then → LOAD.
  - `re` is 0 in all other states.
- **LOAD** (1 cycle)
  - Capture `rdata` into the shift register and clear the bit and cycle counters, then → SEND.
- **SEND** (BITS×T_BIT cycles)
  - For each bit, MSB first, `dout`=1 for T1H cycles if the bit is 1, or T0H cycles if it is 0.
  - `dout`=0 for the rest of the T_BIT period.
  - After the last bit:
    - `led` < NLEDS-1 → increment `led`, → FETCH.
    - `led` = NLEDS-1 → LATCH.
  - `dout` is held 0 during FETCH and LOAD. The resulting 2-cycle low extension between LEDs is intended.
- **LATCH** (T_RESET cycles)
  - `dout`=0.
  - On the final cycle → IDLE and `done` pulses; `busy` drops in the same cycle.
- Counter widths:
  - cycle counter: $clog2(max(T_BIT, T_RESET)+1)
  - bit counter: $clog2(BITS+1)
  - `led`: AWIDTH
  - No wrap occurs within a frame.
- Each RAM word is read exactly once per frame. Writes to the RAM during a frame take effect only for words not yet fetched.
- Asserting `rst_n` low mid-frame forces the reset values immediately, with `dout`=0. The next frame starts from LED 0.

## Timing
- Start accepted at edge N:
  - `busy`=1 and `re`=1 at N+1
  - shift register loaded at N+2
  - first `dout` rise at N+3
- Per LED: 2 + BITS×T_BIT cycles.
- Frame: `busy` high for NLEDS×(2+BITS×T_BIT)+T_RESET cycles, with `done` in the last of them.
- A `start` asserted in the same cycle `done` pulses is ignored. A `start` asserted the following cycle (in IDLE) is accepted.
- Every `dout` high pulse is exactly T0H or T1H cycles long.

## Test plan
Bench parameters: NLEDS=2, BITS=24, T_BIT=6, T0H=2, T1H=4, T_RESET=10.

1. RAM word 0=0xFF0000, word 1=0x00000F; pulse `start`.
   - `re` is high at raddr 0, then at raddr 1.
   - `dout` shows 8 pulses of 4 cycles, then 16 pulses of 2 cycles (LED 0), then 20 pulses of 2 cycles followed by 4 pulses of 4 cycles (LED 1).
   - `busy` is high for 2×(2+144)+10=302 cycles and `done` pulses once.
2. Hold `start` high continuously: frames run back-to-back, with exactly one idle cycle between `done` and the next `busy` rise.
3. Pulse `start` at cycle 50 of an active frame: no effect on the frame content or length.
4. Assert `rst_n` low at cycle 100 of a frame, release it, then pulse `start`.
   - During reset all outputs are 0.
   - The new frame begins at raddr 0 with a full 302-cycle length.
5. Write word 1=0xAAAAAA while LED 0 is in SEND: LED 1 transmits the alternating pattern 4,2,4,2,… high-cycle pulses.
6. Word 0=0x000000 and word 1=0x000000: 48 pulses of 2 cycles each; `dout` is never high for more than 2 consecutive cycles.
